// File: rtl/serial_to_multiple_pkg.sv
// Shared constants and types for the serial-to-multiple packet distributor.
package serial_to_multiple_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int CNT_W_DEFAULT  = 16;
    localparam int N_OUT_DEFAULT  = 2;
    localparam int N_OUT_MAX      = 8;
    localparam int FIFO_DEPTH     = 2;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_BODY = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/serial_to_multiple_fifo.sv
// Two-entry per-port FIFO; head is presented combinationally from storage.
module s2m_skid_fifo
    import serial_to_multiple_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEFAULT + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0]    mem [FIFO_DEPTH];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                push;
    logic                pop;

    assign in_ready  = (count < CNT_BITS'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy tracking; push+pop together leaves count unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_to_multiple.sv
// Distributes whole input packets round-robin across N_OUT buffered output ports.
module serial_to_multiple
    import serial_to_multiple_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int N_OUT  = N_OUT_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       s_tdata,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic [N_OUT*DATA_W-1:0] m_tdata,
    output logic [N_OUT-1:0]        m_tvalid,
    output logic [N_OUT-1:0]        m_tlast,
    input  logic [N_OUT-1:0]        m_tready,
    output logic [N_OUT-1:0]        axis_block,
    output logic                    idle,
    output logic [CNT_W-1:0]        pkt_count
);

    localparam int SEL_W = $clog2(N_OUT_MAX);

    logic [SEL_W-1:0] sel;
    pkt_state_t       state;
    pkt_state_t       state_next;
    logic [N_OUT-1:0] fifo_ready;
    logic [N_OUT-1:0] push_req;
    logic             accept;
    logic [DATA_W:0]  fifo_head [N_OUT];

    // Input readiness and push steering follow only the selected port.
    always_comb begin
        s_tready = 1'b0;
        push_req = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (sel == SEL_W'(k)) begin
                s_tready    = fifo_ready[k];
                push_req[k] = s_tvalid;
            end
        end
    end

    assign accept = s_tvalid && s_tready;

    for (genvar k = 0; k < N_OUT; k++) begin : g_port
        s2m_skid_fifo #(
            .WIDTH (DATA_W + 1)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .in_data   ({s_tlast, s_tdata}),
            .in_valid  (push_req[k]),
            .in_ready  (fifo_ready[k]),
            .out_data  (fifo_head[k]),
            .out_valid (m_tvalid[k]),
            .out_ready (m_tready[k])
        );
        assign m_tdata[k*DATA_W +: DATA_W] = fifo_head[k][DATA_W-1:0];
        assign m_tlast[k]                  = fifo_head[k][DATA_W];
    end

    // Port pointer advances only once a packet's last beat has been taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel <= '0;
        end else if (accept && s_tlast) begin
            sel <= (sel == SEL_W'(N_OUT - 1)) ? '0 : sel + SEL_W'(1);
        end
    end

    // Completed-packet counter, wrapping naturally at its width.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (accept && s_tlast) begin
            pkt_count <= pkt_count + CNT_W'(1);
        end
    end

    // Registered downstream back-pressure indication per port.
    always_ff @(posedge clock) begin
        if (reset) begin
            axis_block <= '0;
        end else begin
            axis_block <= m_tvalid & ~m_tready;
        end
    end

    // Packet-position state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= PKT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Mid-packet tracking: any accepted beat decides by its tlast.
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = s_tlast ? PKT_IDLE : PKT_BODY;
        end
    end

    assign idle = (state == PKT_IDLE) && (m_tvalid == '0);

endmodule

// File: tb/tb_serial_to_multiple.sv
// Directed self-checking bench for serial_to_multiple (N_OUT=2/CNT_W=4 and N_OUT=4).
module tb_serial_to_multiple;

    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    logic [DW-1:0]   s_tdata2;
    logic            s_tvalid2;
    logic            s_tlast2;
    logic            s_tready2;
    logic [2*DW-1:0] m_tdata2;
    logic [1:0]      m_tvalid2;
    logic [1:0]      m_tlast2;
    logic [1:0]      m_tready2;
    logic [1:0]      axis_block2;
    logic            idle2;
    logic [3:0]      pkt_count2;

    logic [DW-1:0]   s_tdata4;
    logic            s_tvalid4;
    logic            s_tlast4;
    logic            s_tready4;
    logic [4*DW-1:0] m_tdata4;
    logic [3:0]      m_tvalid4;
    logic [3:0]      m_tlast4;
    logic [3:0]      m_tready4;
    logic [3:0]      axis_block4;
    logic            idle4;
    logic [15:0]     pkt_count4;

    serial_to_multiple #(
        .DATA_W (DW),
        .N_OUT  (2),
        .CNT_W  (4)
    ) dut2 (
        .clock      (clock),
        .reset      (reset),
        .s_tdata    (s_tdata2),
        .s_tvalid   (s_tvalid2),
        .s_tlast    (s_tlast2),
        .s_tready   (s_tready2),
        .m_tdata    (m_tdata2),
        .m_tvalid   (m_tvalid2),
        .m_tlast    (m_tlast2),
        .m_tready   (m_tready2),
        .axis_block (axis_block2),
        .idle       (idle2),
        .pkt_count  (pkt_count2)
    );

    serial_to_multiple #(
        .DATA_W (DW),
        .N_OUT  (4),
        .CNT_W  (16)
    ) dut4 (
        .clock      (clock),
        .reset      (reset),
        .s_tdata    (s_tdata4),
        .s_tvalid   (s_tvalid4),
        .s_tlast    (s_tlast4),
        .s_tready   (s_tready4),
        .m_tdata    (m_tdata4),
        .m_tvalid   (m_tvalid4),
        .m_tlast    (m_tlast4),
        .m_tready   (m_tready4),
        .axis_block (axis_block4),
        .idle       (idle4),
        .pkt_count  (pkt_count4)
    );

    int checks = 0;
    int errors = 0;

    // Packets 3,1,4 beats into two ports.
    int b_port [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    bit b_last [8] = '{0, 0, 1, 1, 0, 0, 0, 1};

    // 8-beat packet, port 0 stalled in cycles 2..5.
    bit c_rdy  [14] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int c_head [14] = '{-1, 0, 1, 1, 1, 1, 1, 2, 3, 4, 5, 6, 7, -1};
    bit c_blk  [14] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};

    // Port 1 permanently stalled.
    logic [31:0] d_data [7] = '{32'h20, 32'h30, 32'h31, 32'h40, 32'h41, 32'h42, 32'h50};
    bit          d_last [7] = '{1, 0, 1, 0, 0, 1, 0};
    bit          d_rdy  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic [1:0]  d_vld  [8] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
    logic [1:0]  d_blk  [8] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    int          d_h0   [8] = '{-1, 32'h20, -1, -1, 32'h40, 32'h41, 32'h42, -1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_pulse();
        s_tvalid2 = 1'b0;
        s_tlast2  = 1'b0;
        s_tvalid4 = 1'b0;
        s_tlast4  = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bi;

        s_tdata2  = '0;
        s_tvalid2 = 1'b0;
        s_tlast2  = 1'b0;
        m_tready2 = 2'b11;
        s_tdata4  = '0;
        s_tvalid4 = 1'b0;
        s_tlast4  = 1'b0;
        m_tready4 = 4'b1111;

        // Reset state, while reset is held and in the first cycle after release.
        tick();
        tick();
        chk("rst_mvalid2", 64'(m_tvalid2), 64'(0));
        chk("rst_idle2", 64'(idle2), 64'(1));
        chk("rst_block2", 64'(axis_block2), 64'(0));
        chk("rst_cnt2", 64'(pkt_count2), 64'(0));
        chk("rst_mvalid4", 64'(m_tvalid4), 64'(0));
        chk("rst_idle4", 64'(idle4), 64'(1));
        reset = 1'b0;
        tick();
        chk("post_rst_ready2", 64'(s_tready2), 64'(1));
        chk("post_rst_mvalid2", 64'(m_tvalid2), 64'(0));
        chk("post_rst_idle2", 64'(idle2), 64'(1));
        chk("post_rst_ready4", 64'(s_tready4), 64'(1));

        // Packets of length 3,1,4 with full downstream readiness.
        m_tready2 = 2'b11;
        for (int i = 0; i < 8; i++) begin
            s_tvalid2 = 1'b1;
            s_tdata2  = 32'hA000 + 32'(i);
            s_tlast2  = b_last[i];
            chk("rr_ready", 64'(s_tready2), 64'(1));
            tick();
            chk("rr_mvalid", 64'(m_tvalid2), (b_port[i] == 1) ? 64'(2'b10) : 64'(2'b01));
            chk("rr_data", 64'(m_tdata2[b_port[i]*DW +: DW]), 64'(32'hA000 + 32'(i)));
            chk("rr_last", 64'(m_tlast2[b_port[i]]), 64'(b_last[i]));
        end
        s_tvalid2 = 1'b0;
        s_tlast2  = 1'b0;
        tick();
        chk("rr_count", 64'(pkt_count2), 64'(3));
        chk("rr_drained", 64'(m_tvalid2), 64'(0));
        chk("rr_idle", 64'(idle2), 64'(1));

        // 8-beat packet into port 0 with a downstream stall in cycles 2..5.
        reset_pulse();
        bi = 0;
        for (int c = 0; c < 14; c++) begin
            s_tvalid2 = (bi < 8);
            s_tdata2  = 32'h10 + 32'(bi);
            s_tlast2  = (bi == 7);
            m_tready2 = {1'b1, !(c >= 2 && c <= 5)};
            chk("stall_ready", 64'(s_tready2), 64'(c_rdy[c]));
            chk("stall_mvalid", 64'(m_tvalid2), (c_head[c] >= 0) ? 64'(2'b01) : 64'(2'b00));
            if (c_head[c] >= 0) begin
                chk("stall_data", 64'(m_tdata2[DW-1:0]), 64'(32'h10 + 32'(c_head[c])));
                chk("stall_last", 64'(m_tlast2[0]), 64'(c_head[c] == 7));
            end
            chk("stall_block", 64'(axis_block2), 64'({1'b0, c_blk[c]}));
            if (c_rdy[c] && bi < 8) begin
                bi++;
            end
            tick();
        end

        // Port 1 stalled permanently: only the selected port gates input.
        reset_pulse();
        m_tready2 = 2'b01;
        bi = 0;
        for (int c = 0; c < 8; c++) begin
            s_tvalid2 = (bi < 7);
            s_tdata2  = d_data[(bi < 7) ? bi : 6];
            s_tlast2  = (bi < 7) ? d_last[bi] : 1'b0;
            chk("p1stall_ready", 64'(s_tready2), 64'(d_rdy[c]));
            chk("p1stall_mvalid", 64'(m_tvalid2), 64'(d_vld[c]));
            chk("p1stall_block", 64'(axis_block2), 64'(d_blk[c]));
            if (d_h0[c] >= 0) begin
                chk("p1stall_h0", 64'(m_tdata2[DW-1:0]), 64'(d_h0[c]));
            end
            if (c >= 2) begin
                chk("p1stall_h1", 64'(m_tdata2[DW +: DW]), 64'(32'h30));
            end
            if (d_rdy[c] && bi < 7) begin
                bi++;
            end
            tick();
        end
        m_tready2 = 2'b11;
        chk("p1release_ready0", 64'(s_tready2), 64'(0));
        tick();
        chk("p1release_ready1", 64'(s_tready2), 64'(1));
        chk("p1release_h1", 64'(m_tdata2[DW +: DW]), 64'(32'h31));
        chk("p1release_last", 64'(m_tlast2[1]), 64'(1));
        chk("p1release_block", 64'(axis_block2), 64'(0));
        tick();

        // Reset in the middle of a 5-beat packet discards buffered beats.
        reset_pulse();
        m_tready2 = 2'b00;
        s_tvalid2 = 1'b1;
        s_tlast2  = 1'b0;
        s_tdata2  = 32'h60;
        tick();
        s_tdata2  = 32'h61;
        tick();
        s_tvalid2 = 1'b0;
        chk("midrst_pre_mvalid", 64'(m_tvalid2), 64'(2'b01));
        chk("midrst_pre_idle", 64'(idle2), 64'(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_mvalid", 64'(m_tvalid2), 64'(0));
        chk("midrst_idle", 64'(idle2), 64'(1));
        chk("midrst_ready", 64'(s_tready2), 64'(1));
        m_tready2 = 2'b11;
        s_tvalid2 = 1'b1;
        s_tdata2  = 32'h70;
        s_tlast2  = 1'b1;
        tick();
        s_tvalid2 = 1'b0;
        s_tlast2  = 1'b0;
        chk("midrst_next_mvalid", 64'(m_tvalid2), 64'(2'b01));
        chk("midrst_next_data", 64'(m_tdata2[DW-1:0]), 64'(32'h70));
        chk("midrst_next_last", 64'(m_tlast2[0]), 64'(1));
        tick();
        chk("midrst_count", 64'(pkt_count2), 64'(1));
        chk("midrst_idle_after", 64'(idle2), 64'(1));

        // 17 single-beat packets wrap a 4-bit counter to 1.
        reset_pulse();
        m_tready2 = 2'b11;
        for (int i = 0; i < 17; i++) begin
            s_tvalid2 = 1'b1;
            s_tdata2  = 32'(i);
            s_tlast2  = 1'b1;
            chk("wrap_count", 64'(pkt_count2), 64'(i % 16));
            tick();
        end
        s_tvalid2 = 1'b0;
        s_tlast2  = 1'b0;
        chk("wrap_final", 64'(pkt_count2), 64'(1));

        // Four ports, single-beat packets every cycle.
        m_tready4 = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            s_tvalid4 = 1'b1;
            s_tdata4  = 32'h80 + 32'(i);
            s_tlast4  = 1'b1;
            chk("n4_ready", 64'(s_tready4), 64'(1));
            tick();
            chk("n4_mvalid", 64'(m_tvalid4), 64'(4'b0001 << (i % 4)));
            chk("n4_data", 64'(m_tdata4[(i % 4)*DW +: DW]), 64'(32'h80 + 32'(i)));
            chk("n4_last", 64'(m_tlast4[i % 4]), 64'(1));
            chk("n4_count", 64'(pkt_count4), 64'(i + 1));
        end
        s_tvalid4 = 1'b0;
        s_tlast4  = 1'b0;
        tick();
        chk("n4_drained", 64'(m_tvalid4), 64'(0));
        chk("n4_idle", 64'(idle4), 64'(1));
        chk("n4_block", 64'(axis_block4), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_to_multiple.md
SERIAL_TO_MULTIPLE -- requirements
Module: serial_to_multiple

Interface
REQ-001 Parameter DATA_W, default 32, width of every tdata bus.
REQ-002 Parameter N_OUT, default 2, number of output streams; legal range 2..8.
REQ-003 Parameter CNT_W, default 16, width of the packet counter.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_tdata  input  DATA_W  serial input stream data.
REQ-007 s_tvalid  input  1  input beat valid.
REQ-008 s_tlast  input  1  last beat of the input packet.
REQ-009 s_tready  output  1  input beat accepted when s_tvalid and s_tready are both high.
REQ-010 m_tdata  output  N_OUT*DATA_W  output data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-011 m_tvalid, m_tlast  output  N_OUT each  per-port valid and last.
REQ-012 m_tready  input  N_OUT  per-port downstream ready.
REQ-013 axis_block  output  N_OUT  bit k is high when m_tvalid[k]=1 and m_tready[k]=0 (registered).
REQ-014 idle  output  1  no beat is held in any buffer and the input is not mid-packet.
REQ-015 pkt_count  output  CNT_W  count of completed input packets (s_tlast accepted).

Function
REQ-016 Whole packets SHALL go round-robin to ports 0,1,..,N_OUT-1,0,..; a packet is never split across ports.
REQ-017 Select pointer sel SHALL advance by one, wrapping from N_OUT-1 to 0, in the cycle after a beat with s_tlast=1 is accepted, and at no other time.
REQ-018 Each port SHALL own a 2-entry FIFO holding {tdata, tlast}; m_tvalid[k] = FIFO k non-empty; m_tdata/m_tlast[k] = FIFO k head.
REQ-019 s_tready SHALL equal (count[sel] < 2), so input stalls depend only on the selected port.
REQ-020 An accepted beat SHALL appear on m_tdata[sel] with exactly 1 cycle of latency when FIFO sel was empty.
REQ-021 Simultaneous push and pop on one FIFO SHALL leave count unchanged, preserve order, and sustain one beat per cycle with no bubbles.
REQ-022 Pop on an empty FIFO or push on a full one SHALL NOT occur; guard logic SHALL prevent it.
REQ-023 Non-selected ports SHALL keep draining independently while the selected port stalls.
REQ-024 A stall on a non-selected port SHALL NOT deassert s_tready.
REQ-025 pkt_count SHALL increment by 1 per accepted s_tlast beat and wrap modulo 2^CNT_W.
REQ-026 in_pkt flag: set on an accepted beat with s_tlast=0, cleared on an accepted beat with s_tlast=1; idle = !in_pkt and all counts zero.
REQ-027 axis_block SHALL be registered one cycle after the condition in REQ-013.

Reset
REQ-028 On reset: sel=0, all FIFO counts and pointers 0, in_pkt=0, pkt_count=0, axis_block=0.
REQ-029 During and after reset, outputs SHALL be m_tvalid=0, s_tready=1 in the first cycle after reset deasserts, and idle=1.
REQ-030 Reset mid-packet SHALL discard buffered beats; the next packet goes to port 0.

Structure
REQ-031 A shared package SHALL hold the default widths, the maximum N_OUT, and the FIFO depth constant (2).
REQ-032 The 2-entry FIFO SHALL be one sub-module, s2m_skid_fifo, instantiated N_OUT times via generate.

Verification
REQ-033 Packets with lengths 3,1,4, all m_tready=1 -> port0 gets 3 beats, port1 gets 1, port0 gets 4; tlast on beats 3, 1, 4; pkt_count=3; zero-bubble throughput.
REQ-034 Continuous 8-beat packet, m_tready[0]=0 for cycles 2-5 -> s_tready low once FIFO0 holds 2 beats; data order intact; axis_block[0] high from 1 cycle after the stall starts.
REQ-035 m_tready[1]=0 permanently while a packet goes to port0 -> s_tready stays 1 until sel=1 and FIFO1 is full.
REQ-036 Single-beat packets every cycle with N_OUT=4 -> ports receive 0,1,2,3,0 in order; pkt_count increments every cycle.
REQ-037 Reset asserted after beat 2 of a 5-beat packet -> all m_tvalid=0, idle=1; next packet appears on port 0.
REQ-038 CNT_W=4, 17 packets -> pkt_count wraps to 1.
